// File: rtl/dma_ctrl_mc.sv
// Multi-channel DMA controller: per-channel descriptors, round-robin channel
// selection and read-then-write transfers (single or burst) on a shared bus.
module dma_ctrl_mc #(
  parameter int NCH    = 2,
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 4
) (
  input  logic                  clk,
  input  logic                  reset_,
  input  logic [NCH-1:0]        dreq_,
  input  logic [NCH*ADDR_W-1:0] dsaddr,
  input  logic [NCH*ADDR_W-1:0] ddaddr,
  input  logic [NCH*2-1:0]      dmode,
  input  logic [NCH*CNT_W-1:0]  dcnt,
  output logic [NCH-1:0]        eop_,
  output logic [NCH-1:0]        busy,
  output logic                  breq_,
  input  logic                  bgrt_,
  output logic [ADDR_W-1:0]     addr,
  output logic                  rw_,
  output logic [DATA_W-1:0]     wdata,
  input  logic [DATA_W-1:0]     rdata
);
  localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_RD, S_WR, S_DONE} state_t;

  state_t            r_state;
  logic [IW-1:0]     r_cur;
  logic [IW-1:0]     r_rr;
  logic [NCH-1:0]    r_busy;
  logic [NCH-1:0]    r_eopN;
  logic              r_breqN;
  logic              r_rw;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [ADDR_W-1:0] r_src  [NCH];
  logic [ADDR_W-1:0] r_dst  [NCH];
  logic [1:0]        r_mode [NCH];
  logic [CNT_W-1:0]  r_rem  [NCH];

  logic              w_found;
  logic [IW-1:0]     w_pick;
  logic [IW-1:0]     w_pickNext;
  logic [1:0]        w_mode;
  logic [ADDR_W-1:0] w_srcNext;
  logic [ADDR_W-1:0] w_dstNext;

  // The second pass (channels at or after r_rr) overrides the first, so the
  // lowest busy index in rotation order starting from r_rr wins.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    for (int i = NCH-1; i >= 0; i--) begin
      if (r_busy[i] && (i < int'(r_rr))) begin
        w_found = 1'b1;
        w_pick  = IW'(i);
      end
    end
    for (int i = NCH-1; i >= 0; i--) begin
      if (r_busy[i] && (i >= int'(r_rr))) begin
        w_found = 1'b1;
        w_pick  = IW'(i);
      end
    end
    w_pickNext = (int'(w_pick) == NCH-1) ? '0 : w_pick + IW'(1);
  end

  always_comb begin
    w_mode    = r_mode[r_cur];
    w_srcNext = (w_mode == 2'd3) ? r_src[r_cur] : r_src[r_cur] + ADDR_W'(1);
    w_dstNext = (w_mode == 2'd2) ? r_dst[r_cur] : r_dst[r_cur] + ADDR_W'(1);
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      r_state <= S_IDLE;
      r_cur   <= '0;
      r_rr    <= '0;
      r_busy  <= '0;
      r_eopN  <= '1;
      r_breqN <= 1'b1;
      r_rw    <= 1'b1;
      r_addr  <= '0;
      r_wdata <= '0;
      for (int i = 0; i < NCH; i++) begin
        r_src[i]  <= '0;
        r_dst[i]  <= '0;
        r_mode[i] <= '0;
        r_rem[i]  <= '0;
      end
    end else begin
      r_eopN <= '1;
      for (int i = 0; i < NCH; i++) begin
        if (!dreq_[i] && !r_busy[i]) begin
          r_src[i]  <= dsaddr[i*ADDR_W +: ADDR_W];
          r_dst[i]  <= ddaddr[i*ADDR_W +: ADDR_W];
          r_mode[i] <= dmode[i*2 +: 2];
          r_rem[i]  <= dcnt[i*CNT_W +: CNT_W];
          r_busy[i] <= 1'b1;
        end
      end
      unique case (r_state)
        S_IDLE: begin
          r_breqN <= 1'b1;
          if (w_found) begin
            r_cur   <= w_pick;
            r_rr    <= w_pickNext;
            r_breqN <= 1'b0;
            r_state <= S_REQ;
          end
        end
        S_REQ: begin
          if (!bgrt_) begin
            r_addr  <= r_src[r_cur];
            r_rw    <= 1'b1;
            r_state <= S_RD;
          end
        end
        S_RD: begin
          r_addr  <= r_dst[r_cur];
          r_rw    <= 1'b0;
          r_state <= S_WR;
        end
        S_WR: begin
          r_rw <= 1'b1;
          // Losing the grant here drops the write; the read is redone after regrant.
          if (bgrt_) begin
            r_state <= S_REQ;
          end else begin
            r_wdata      <= rdata;
            r_src[r_cur] <= w_srcNext;
            r_dst[r_cur] <= w_dstNext;
            if (r_rem[r_cur] == '0) begin
              r_breqN        <= 1'b1;
              r_eopN[r_cur]  <= 1'b0;
              r_busy[r_cur]  <= 1'b0;
              r_state        <= S_DONE;
            end else begin
              r_rem[r_cur] <= r_rem[r_cur] - CNT_W'(1);
              if (w_mode == 2'd0) begin
                r_breqN <= 1'b1;
                r_state <= S_IDLE;
              end else begin
                r_addr  <= w_srcNext;
                r_state <= S_RD;
              end
            end
          end
        end
        S_DONE: begin
          r_breqN <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign eop_  = r_eopN;
  assign busy  = r_busy;
  assign breq_ = r_breqN;
  assign addr  = r_addr;
  assign rw_   = r_rw;
  // Read data only becomes valid during WR, so it is forwarded straight onto
  // the bus then; r_wdata keeps the last committed value for other states.
  assign wdata = (r_state == S_WR) ? rdata : r_wdata;

endmodule
